// File: rtl/ex_operand_stage_pkg.sv
// Shared constants for the ID/EX operand stage: default widths, ALU source
// encodings and the hard-wired zero register number.
package ex_operand_stage_pkg;

   localparam int DEFAULT_WIDTH  = 32;
   localparam int DEFAULT_ADDR_W = 5;

   localparam logic ALU_SRC_REG = 1'b0;
   localparam logic ALU_SRC_IMM = 1'b1;

   localparam logic [DEFAULT_ADDR_W-1:0] ZERO_REG = '0;

endpackage

// File: rtl/ex_operand_stage_fwd_select.sv
// Combinational forwarding priority matcher for one source operand.
// Lowest matching source index wins; register 0 is never forwarded.
module fwd_select
   import ex_operand_stage_pkg::*;
#(
   parameter int WIDTH   = DEFAULT_WIDTH,
   parameter int ADDR_W  = DEFAULT_ADDR_W,
   parameter int NUM_FWD = 2
) (
   input  logic [ADDR_W-1:0]         addr,
   input  logic                      use_op,
   input  logic [WIDTH-1:0]          rf_value,
   input  logic [NUM_FWD-1:0]        fwd_valid,
   input  logic [NUM_FWD*ADDR_W-1:0] fwd_addr,
   input  logic [NUM_FWD-1:0]        fwd_ready,
   input  logic [NUM_FWD*WIDTH-1:0]  fwd_data,
   output logic [WIDTH-1:0]          value,
   output logic                      not_ready
);

   logic win_ready;
   logic matched;

   // Walk from the oldest source down so the youngest match is written last.
   always_comb begin
      value     = rf_value;
      win_ready = 1'b1;
      matched   = 1'b0;
      for (int i = NUM_FWD - 1; i >= 0; i--) begin
         if (fwd_valid[i] && (fwd_addr[i*ADDR_W +: ADDR_W] == addr) &&
             (addr != ADDR_W'(ZERO_REG))) begin
            value     = fwd_data[i*WIDTH +: WIDTH];
            win_ready = fwd_ready[i];
            matched   = 1'b1;
         end
      end
   end

   assign not_ready = use_op && matched && !win_ready;

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX operand stage: forwarding resolution, load-use stall and EX pipeline
// register with valid/ready handshake. Optional bubble counter: EX_OPERAND_BUBBLE_CNT_EN.
module ex_operand_stage
   import ex_operand_stage_pkg::*;
#(
   parameter int WIDTH   = DEFAULT_WIDTH,
   parameter int NUM_FWD = 2,
   parameter int ADDR_W  = DEFAULT_ADDR_W
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [ADDR_W-1:0]         rs_addr,
   input  logic [ADDR_W-1:0]         rt_addr,
   input  logic                      use_rs,
   input  logic                      use_rt,
   input  logic [WIDTH-1:0]          rd1,
   input  logic [WIDTH-1:0]          rd2,
   input  logic [WIDTH-1:0]          ext_imm,
   input  logic                      alu_src,
   input  logic [NUM_FWD-1:0]        fwd_valid,
   input  logic [NUM_FWD*ADDR_W-1:0] fwd_addr,
   input  logic [NUM_FWD-1:0]        fwd_ready,
   input  logic [NUM_FWD*WIDTH-1:0]  fwd_data,
   input  logic                      flush,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [WIDTH-1:0]          src_a,
   output logic [WIDTH-1:0]          src_b,
   output logic [WIDTH-1:0]          store_data,
   output logic                      hazard,
   output logic [31:0]               bubble_cnt
);

   logic [WIDTH-1:0] rs_value;
   logic [WIDTH-1:0] rt_value;
   logic             rs_not_ready;
   logic             rt_not_ready;
   logic             transfer;

   fwd_select #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .NUM_FWD(NUM_FWD)) u_rs_sel (
      .addr      (rs_addr),
      .use_op    (use_rs),
      .rf_value  (rd1),
      .fwd_valid (fwd_valid),
      .fwd_addr  (fwd_addr),
      .fwd_ready (fwd_ready),
      .fwd_data  (fwd_data),
      .value     (rs_value),
      .not_ready (rs_not_ready)
   );

   fwd_select #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .NUM_FWD(NUM_FWD)) u_rt_sel (
      .addr      (rt_addr),
      .use_op    (use_rt),
      .rf_value  (rd2),
      .fwd_valid (fwd_valid),
      .fwd_addr  (fwd_addr),
      .fwd_ready (fwd_ready),
      .fwd_data  (fwd_data),
      .value     (rt_value),
      .not_ready (rt_not_ready)
   );

   assign hazard   = in_valid && (rs_not_ready || rt_not_ready);
   assign in_ready = (!out_valid || out_ready) && !hazard && !flush;
   assign transfer = in_valid && in_ready;

   // Flush beats everything; a stalled slot with out_ready high drains to a bubble.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid  <= 1'b0;
         src_a      <= '0;
         src_b      <= '0;
         store_data <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (transfer) begin
         out_valid  <= 1'b1;
         src_a      <= rs_value;
         src_b      <= (alu_src == ALU_SRC_IMM) ? ext_imm : rt_value;
         store_data <= rt_value;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef EX_OPERAND_BUBBLE_CNT_EN
   logic [31:0] bubble_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bubble_q <= '0;
      end else if (hazard && !flush && (!out_valid || out_ready) &&
                   (bubble_q != 32'hFFFF_FFFF)) begin
         bubble_q <= bubble_q + 32'd1;
      end
   end

   assign bubble_cnt = bubble_q;
`else
   assign bubble_cnt = '0;
`endif

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- Parametrised successor to the single-cycle ALU-source selector, used at the ID/EX boundary of the pipelined datapath.
- Selects operand A (rs value) and operand B (rt value or extended immediate), resolving register read-after-write hazards against NUM_FWD younger pipeline stages.
- Detects forwarding hazards where the data is not yet available (load-use), and holds the instruction until it is.
- Registers the resolved operands into an EX-side pipeline register with valid/ready handshake and flush.

Parameters:
- WIDTH, 32, datapath width of register values, immediate and forwarded data.
- NUM_FWD, 2, number of forwarding sources; index 0 is the youngest stage and has the highest priority.
- ADDR_W, 5, register-number width.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  ID stage presents an instruction.
- in_ready  out  1  stage accepts the instruction this cycle.
- rs_addr  in  ADDR_W  source register A number.
- rt_addr  in  ADDR_W  source register B number.
- use_rs  in  1  instruction reads rs.
- use_rt  in  1  instruction reads rt (ALU operand or store data).
- rd1  in  WIDTH  register-file value of rs.
- rd2  in  WIDTH  register-file value of rt.
- ext_imm  in  WIDTH  extended immediate.
- alu_src  in  1  0 selects the rt value for src_b; 1 selects ext_imm.
- fwd_valid  in  NUM_FWD  source i will write a register.
- fwd_addr  in  NUM_FWD*ADDR_W  destination register of source i (slice i).
- fwd_ready  in  NUM_FWD  data of source i is available this cycle.
- fwd_data  in  NUM_FWD*WIDTH  write data of source i (slice i).
- flush  in  1  kill the held instruction and the instruction presented this cycle.
- out_valid  out  1  EX register holds a valid instruction.
- out_ready  in  1  EX consumes the instruction this cycle.
- src_a  out  WIDTH  registered operand A.
- src_b  out  WIDTH  registered operand B.
- store_data  out  WIDTH  registered forwarded rt value, independent of alu_src.
- hazard  out  1  combinational; unresolved load-use dependency.
- bubble_cnt  out  32  bubble counter (see Optional Feature).

Behaviour:
- Reset (async assert, sync-released in the clock domain):
  - out_valid=0; src_a, src_b and store_data = 0; bubble_cnt=0.
  - Reset asserted mid-transfer discards everything immediately.
- Forward match for operand X:
  - Source i matches when fwd_valid[i] && fwd_addr[i]==X_addr && X_addr!=0.
  - The lowest matching index wins.
  - Register 0 is never forwarded; its value is rd1/rd2 as given.
  - No match: use rd1 (operand A) or rd2 (operand B).
- Resolved values:
  - The winning source supplies fwd_data[i].
  - The rt-resolved value feeds store_data always, and feeds src_b only when alu_src=0.
- Hazard:
  - hazard=1 if (use_rs and the rs winner has fwd_ready=0) or (use_rt and the rt winner has fwd_ready=0).
  - A ready older source never masks a non-ready younger winner.
  - hazard is qualified by in_valid.
- Handshake:
  - in_ready = (!out_valid || out_ready) && !hazard && !flush.
  - Transfer occurs when in_valid && in_ready: the register loads all three operands and out_valid<=1 on the next edge.
  - If out_ready=1 and no transfer, out_valid<=0 (bubble).
  - If out_valid=1 and out_ready=0, the register holds its contents, unchanged, until consumed.
  - Throughput is one instruction per cycle; latency is 1 cycle from acceptance to out_valid.
- Flush: highest priority. Next edge gives out_valid<=0 and nothing is loaded; the data registers may retain stale values.
- Simultaneous events:
  - flush together with a hazard: flush wins; no counter increment.
  - out_ready together with a new transfer: back-to-back load, out_valid stays 1.

Optional Feature:
- Macro: EX_OPERAND_BUBBLE_CNT_EN.
- Defined: bubble_cnt increments by 1 on each edge where in_valid && hazard && !flush && (!out_valid || out_ready). It saturates at 32'hFFFF_FFFF and is cleared by reset.
- Undefined: bubble_cnt is tied to 0 and no counter flops are inferred.

Decomposition:
- Shared package/header holds:
  - default WIDTH and ADDR_W;
  - ALU_SRC_REG=1'b0 and ALU_SRC_IMM=1'b1;
  - the ZERO_REG constant.
- Sub-module fwd_select: combinational priority matcher. Inputs: one register address, the use flag and the fwd buses. Outputs: the resolved value and a not-ready flag. It is instantiated twice (rs and rt).

Test Plan:
- No forwards; rs=3, rd1=0x11, rt=4, rd2=0x22, alu_src=0, out_ready=1 -> next cycle out_valid=1, src_a=0x11, src_b=0x22, store_data=0x22.
- alu_src=1, ext_imm=0xFFFF_FFFC, rt=4 matched by fwd[1] (ready, data=0x55) -> src_b=0xFFFF_FFFC, store_data=0x55.
- rs=5 matched by fwd[0] (data 0xA) and fwd[1] (data 0xB), both ready -> src_a=0xA. rs=0 with fwd_addr[0]=0 -> src_a=rd1.
- rs=7 matched by fwd[0] with fwd_ready=0 for 2 cycles, then ready with data 0x77 -> hazard=1 and in_ready=0 for 2 cycles, 2 bubbles out, bubble_cnt=2 (macro defined), then src_a=0x77.
- out_ready=0 for 3 cycles while out_valid=1 -> src_a/src_b held constant, in_ready=0. Assert flush in cycle 2 -> out_valid=0 on the next edge.
- Assert reset_n=0 asynchronously mid-stream between edges -> out_valid and src_a/src_b/store_data drop to 0 immediately; after release, the first transfer is correct.
